pipe_rot: RTL and testbench
===========================

PIPE_ROT -- requirements
Module: pipe_rot

Interface
REQ-001 Parameter N, default 32, data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter LOG2_N, default 5, SHALL equal log2(N); it is both the shift-amount width and the pipeline depth.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 bits  input  [0:N-1]  data word; index 0 is the leftmost bit.
REQ-008 k  input  [0:LOG2_N-1]  shift amount; k[0] has weight N/2 and k[LOG2_N-1] has weight 1.
REQ-009 mode  input  [1:0]  operation: 00 rotate right, 01 rotate left, 10 logical shift right, 11 arithmetic shift right.
REQ-010 out_valid  output  1  result word available.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 rotated_bits  output  [0:N-1]  result word.

Function
REQ-013 Right operations (modes 00, 10, 11) SHALL move bits toward higher index: out[i] = in[i-k].
REQ-014 Rotate right SHALL wrap modulo N. Rotate left SHALL produce out[i] = in[(i+k) mod N].
REQ-015 Logical shift right SHALL fill vacated positions 0..k-1 with 0; arithmetic shift right SHALL fill them with in[0].
REQ-016 k = 0 SHALL pass the word unchanged in all modes.
REQ-017 The datapath SHALL consist of LOG2_N registered stages. Stage s SHALL apply the shift of weight N>>(s+1) when k[s] = 1, applied with the requested mode.
REQ-018 Each stage register SHALL carry valid, data, the remaining k bits and mode.
REQ-019 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-020 Latency SHALL be exactly LOG2_N cycles from input transfer to out_valid, assuming no stall.
REQ-021 Throughput SHALL be one word per cycle while out_ready = 1.
REQ-022 stall = out_valid && !out_ready. When stall is 1, every stage register SHALL hold its contents, and in_ready SHALL equal !stall.
REQ-023 Bubbles (invalid stages) SHALL advance while there is no stall; data in invalid stages is don't-care.
REQ-024 rotated_bits SHALL remain stable while out_valid && !out_ready.
REQ-025 Simultaneous output and input transfers in the same cycle SHALL both complete without loss or duplication.
REQ-026 Mode and k SHALL be sampled with their word only; changing them while words are in flight SHALL NOT affect those words.

Reset
REQ-027 When rst_n is low, all stage valid bits SHALL clear immediately (asynchronously), out_valid SHALL be 0, and rotated_bits SHALL be all 0.
REQ-028 Words in flight when reset asserts SHALL be discarded, and no output transfer SHALL occur for them.
REQ-029 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro PIPE_ROT_XFER_COUNT_EN SHALL control an extra 16-bit output, xfer_count.
REQ-031 With PIPE_ROT_XFER_COUNT_EN defined, xfer_count SHALL increment on each output transfer, wrap from 0xFFFF to 0x0000, and reset to 0.
REQ-032 Without PIPE_ROT_XFER_COUNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification (N=8, LOG2_N=3; words written index 0 first)
REQ-033 Rotate right by 1: bits 10000001, k=001, mode 00 -> rotated_bits 11000000 exactly 3 cycles later.
REQ-034 Rotate left by 3: bits 10000001, k=011, mode 01 -> rotated_bits 00001100.
REQ-035 Arithmetic and logical shift right by 2: bits 10110000, k=010 -> mode 11 gives 11101100; mode 10 gives 00101100.
REQ-036 Back-to-back streaming with a stall: 8 words, with out_ready held at 0 for 4 cycles mid-stream -> all 8 results appear in order with none lost; in_ready is 0 and rotated_bits is stable during the stall.
REQ-037 Reset mid-flight: pulse rst_n low while 2 words are in flight -> out_valid is 0 at once and no stale word is ever output afterwards.
REQ-038 Counter wrap (PIPE_ROT_XFER_COUNT_EN defined): 65537 output transfers -> xfer_count reads 1.

Source files
------------

// File: rtl/pipe_rot.sv
// Pipelined barrel rotator/shifter: LOG2_N registered stages with valid/ready flow control.
// Optional PIPE_ROT_XFER_COUNT_EN adds a 16-bit xfer_count output counting output transfers.
module pipe_rot #(
  parameter int N      = 32,
  parameter int LOG2_N = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      bits,
  input  logic [0:LOG2_N-1] k,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_ROT_XFER_COUNT_EN
  output logic [15:0]       xfer_count,
`endif
  output logic [0:N-1]      rotated_bits
);

  typedef enum logic [1:0] {
    ROT_R = 2'b00,
    ROT_L = 2'b01,
    SHR_L = 2'b10,
    SHR_A = 2'b11
  } mode_e;

  // Applies one fixed-weight step; index arithmetic wraps mod N by truncation since N is a power of two.
  function automatic logic [0:N-1] stage_shift(input logic [0:N-1] w, input int amt,
                                               input logic en, input logic [1:0] m);
    logic [0:N-1]      r;
    logic [LOG2_N-1:0] pos;
    logic [LOG2_N-1:0] src;
    r = w;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        pos = LOG2_N'(i);
        if (mode_e'(m) == ROT_L) begin
          src    = LOG2_N'(i + amt);
          r[pos] = w[src];
        end else begin
          src = LOG2_N'(i - amt);
          if (i >= amt || mode_e'(m) == ROT_R) r[pos] = w[src];
          else if (mode_e'(m) == SHR_L)        r[pos] = 1'b0;
          else                                 r[pos] = w[0];
        end
      end
    end
    return r;
  endfunction

  logic              valid_q [LOG2_N];
  logic [0:N-1]      data_q  [LOG2_N];
  logic [0:LOG2_N-1] k_q     [LOG2_N];
  logic [1:0]        mode_q  [LOG2_N];
  logic [0:N-1]      shifted [LOG2_N];
  logic              stall;

  assign out_valid    = valid_q[LOG2_N-1];
  assign stall        = out_valid && !out_ready;
  assign in_ready     = !stall;
  assign rotated_bits = shifted[LOG2_N-1];

  // Register s holds the word with steps 0..s-1 applied; step s is applied on its way out.
  for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
    assign shifted[s] = stage_shift(data_q[s], N >> (s + 1), k_q[s][s], mode_q[s]);

    if (s == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[0] <= 1'b0;
          data_q[0]  <= '0;
          k_q[0]     <= '0;
          mode_q[0]  <= '0;
        end else if (!stall) begin
          valid_q[0] <= in_valid;
          data_q[0]  <= bits;
          k_q[0]     <= k;
          mode_q[0]  <= mode;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[s] <= 1'b0;
          data_q[s]  <= '0;
          k_q[s]     <= '0;
          mode_q[s]  <= '0;
        end else if (!stall) begin
          valid_q[s] <= valid_q[s-1];
          data_q[s]  <= shifted[s-1];
          k_q[s]     <= k_q[s-1];
          mode_q[s]  <= mode_q[s-1];
        end
      end
    end
  end

`ifdef PIPE_ROT_XFER_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      xfer_count <= '0;
    else if (out_valid && out_ready) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_rot.sv
// Self-checking bench for pipe_rot at N=8: directed vector table plus streaming, stall and reset sequences.
// Define PIPE_ROT_XFER_COUNT_EN to also exercise the transfer counter wrap.
module tb_pipe_rot;
  localparam int N = 8;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:N-1] bits = '0;
  logic [0:L-1] k = '0;
  logic [1:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:N-1] rotated_bits;
`ifdef PIPE_ROT_XFER_COUNT_EN
  logic [15:0]  xfer_count;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        name;
    logic [0:N-1] b;
    logic [0:L-1] k;
    logic [1:0]   m;
    logic [0:N-1] e;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  pipe_rot #(.N(N), .LOG2_N(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bits         (bits),
    .k            (k),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef PIPE_ROT_XFER_COUNT_EN
    .xfer_count   (xfer_count),
`endif
    .rotated_bits (rotated_bits)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offers one word for a single cycle, scrambles the inputs afterwards, and checks latency and result.
  task automatic applyStimulus(input vec_t v);
    int cnt;
    @(negedge clk);
    bits = v.b; k = v.k; mode = v.m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; bits = ~v.b; k = ~v.k; mode = v.m ^ 2'b01;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({v.name, " latency"}, cnt, 3);
    checkOutput({v.name, " data"}, rotated_bits, v.e);
  endtask

  function automatic logic [0:N-1] rotr1(input logic [7:0] w);
    return (w >> 1) | ((w & 8'h01) << 7);
  endfunction

  initial begin
    logic [0:N-1] words [8];
    logic [0:N-1] held;
    int sent, recv, stall_cycles, cnt;
    bit seen_valid;

    vecs[0]  = '{"rotr1",     8'b10000001, 3'b001, 2'b00, 8'b11000000};
    vecs[1]  = '{"rotl3",     8'b10000001, 3'b011, 2'b01, 8'b00001100};
    vecs[2]  = '{"asr2",      8'b10110000, 3'b010, 2'b11, 8'b11101100};
    vecs[3]  = '{"lsr2",      8'b10110000, 3'b010, 2'b10, 8'b00101100};
    vecs[4]  = '{"k0_rotr",   8'b10110010, 3'b000, 2'b00, 8'b10110010};
    vecs[5]  = '{"k0_rotl",   8'b10110010, 3'b000, 2'b01, 8'b10110010};
    vecs[6]  = '{"k0_asr",    8'b10110010, 3'b000, 2'b11, 8'b10110010};
    vecs[7]  = '{"rotr4",     8'b11010000, 3'b100, 2'b00, 8'b00001101};
    vecs[8]  = '{"rotr7",     8'b10000000, 3'b111, 2'b00, 8'b00000001};
    vecs[9]  = '{"rotl7",     8'b10000000, 3'b111, 2'b01, 8'b01000000};
    vecs[10] = '{"lsr7",      8'b11111111, 3'b111, 2'b10, 8'b00000001};
    vecs[11] = '{"asr7",      8'b10000000, 3'b111, 2'b11, 8'b11111111};
    vecs[12] = '{"asr5_pos",  8'b01111111, 3'b101, 2'b11, 8'b00000011};
    vecs[13] = '{"rotr6",     8'b11000000, 3'b110, 2'b00, 8'b00000011};

    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset rotated_bits", rotated_bits, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", in_ready, 1);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Streaming: 8 back-to-back words with a 4-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) words[i] = 8'(8'h35 * (i + 1) + i);
    sent = 0; recv = 0; stall_cycles = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 10);
      if (sent < 8) begin
        in_valid = 1'b1; bits = words[sent]; k = 3'b001; mode = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        checkOutput("stall in_ready", in_ready, 0);
        if (stall_cycles > 0) checkOutput("stall stable", rotated_bits, held);
        held = rotated_bits;
        stall_cycles++;
      end
      if (out_valid && out_ready) begin
        if (recv < 8) checkOutput($sformatf("stream word %0d", recv), rotated_bits, rotr1(words[recv]));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream count", recv, 8);
    checkOutput("stream stall cycles", stall_cycles, 4);

    // Reset while two words are in flight and the first is waiting at the output.
    @(negedge clk);
    out_ready = 1'b0;
    bits = 8'b10100000; k = 3'b001; mode = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    bits = 8'b01010000;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("pre-reset out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset rotated_bits", rotated_bits, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after mid reset", in_ready, 1);
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("no stale output", seen_valid, 0);

`ifdef PIPE_ROT_XFER_COUNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("xfer_count reset", xfer_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; bits = 8'h5A; k = 3'b010; mode = 2'b00; out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 70000 && cnt < 65537; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("xfer transfers", cnt, 65537);
    checkOutput("xfer_count wrap", xfer_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
